// File: rtl/arith_enc_sched.sv
// Block sequencer for the arithmetic encoder: reinit/start per block, pair pass-through,
// byte merge with a trailing flush of Low, and per-block byte/bit counts.
module arith_enc_sched #(
   parameter int Prob_DW     = 32,
   parameter int FLUSH_BYTES = 4,
   parameter int Cnt_DW      = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic               s_y,
   input  logic [Prob_DW-1:0] s_p,
   input  logic               s_last,
   output logic               enc_rst,
   output logic               enc_start,
   output logic               enc_y,
   output logic [Prob_DW-1:0] enc_p,
   output logic               enc_in_valid,
   input  logic               enc_in_ready,
   input  logic [7:0]         enc_out,
   input  logic               enc_out_valid,
   output logic               enc_out_ready,
   input  logic [Prob_DW-1:0] enc_low,
   output logic [7:0]         m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_last,
   output logic               busy,
   output logic               blk_done,
   output logic [Cnt_DW-1:0]  blk_bytes,
   output logic [Cnt_DW-1:0]  blk_bits
);

   typedef enum logic [2:0] {IDLE, RST, START, FEED, DRAIN, FLUSH, DONE} state_t;

   localparam logic [2:0]        LAST_IDX = 3'(FLUSH_BYTES - 1);
   localparam logic [Cnt_DW-1:0] ONE      = 1;

   state_t             state;
   logic [Prob_DW-1:0] low_q;
   logic [2:0]         fidx;
   logic               drain_arm;
   logic [Cnt_DW-1:0]  byte_cnt, bit_cnt, byte_nxt, bit_nxt;
   logic               feed, pass, flush, s_fire, m_fire;

   assign feed  = (state == FEED);
   assign pass  = (state == FEED) || (state == DRAIN);
   assign flush = (state == FLUSH);

   assign s_ready       = feed & enc_in_ready;
   assign enc_in_valid  = feed & s_valid;
   assign enc_y         = s_y;
   assign enc_p         = s_p;
   assign enc_out_ready = pass & m_ready;

   // Flush bytes come MSB first off a left-shifting copy of Low.
   assign m_valid = pass ? enc_out_valid : flush;
   assign m_data  = pass ? enc_out : (flush ? low_q[Prob_DW-1 -: 8] : 8'h00);
   assign m_last  = flush && (fidx == LAST_IDX);
   assign busy    = (state != IDLE);

   assign s_fire = s_valid & s_ready;
   assign m_fire = m_valid & m_ready;

   // Saturating increments: counters stick at all-ones.
   assign byte_nxt = (m_fire && !(&byte_cnt)) ? byte_cnt + ONE : byte_cnt;
   assign bit_nxt  = (s_fire && !(&bit_cnt))  ? bit_cnt + ONE  : bit_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         enc_rst   <= 1'b0;
         enc_start <= 1'b0;
         blk_done  <= 1'b0;
         blk_bytes <= '0;
         blk_bits  <= '0;
         byte_cnt  <= '0;
         bit_cnt   <= '0;
         low_q     <= '0;
         fidx      <= '0;
         drain_arm <= 1'b0;
      end else begin
         enc_rst   <= 1'b0;
         enc_start <= 1'b0;
         blk_done  <= 1'b0;
         byte_cnt  <= byte_nxt;
         bit_cnt   <= bit_nxt;
         case (state)
            IDLE: if (s_valid) begin
               state   <= RST;
               enc_rst <= 1'b1;
            end
            RST: begin
               state     <= START;
               enc_start <= 1'b1;
               byte_cnt  <= '0;
               bit_cnt   <= '0;
            end
            START: state <= FEED;
            FEED: if (s_fire && s_last) begin
               state     <= DRAIN;
               drain_arm <= 1'b0;
            end
            // Hold one cycle after the last pair so the encoder can drop in_ready.
            DRAIN: begin
               drain_arm <= 1'b1;
               if (drain_arm && enc_in_ready && !enc_out_valid) begin
                  state <= FLUSH;
                  low_q <= enc_low;
                  fidx  <= '0;
               end
            end
            FLUSH: if (m_ready) begin
               low_q <= low_q << 8;
               fidx  <= fidx + 3'd1;
               if (fidx == LAST_IDX) begin
                  state     <= DONE;
                  blk_done  <= 1'b1;
                  blk_bytes <= byte_nxt;
                  blk_bits  <= bit_cnt;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arith_enc_sched.sv
// Bench for arith_enc_sched: behavioural carry-less encoder stub plus a per-block
// reference stream (encoder bytes then Low flush bytes) checked byte by byte.
module tb_arith_enc_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        s_valid, s_ready, s_y, s_last;
   logic [31:0] s_p;
   logic        enc_rst, enc_start, enc_y, enc_in_valid, enc_in_ready;
   logic [31:0] enc_p, enc_low;
   logic [7:0]  enc_out;
   logic        enc_out_valid, enc_out_ready;
   logic [7:0]  m_data;
   logic        m_valid, m_ready, m_last, busy, blk_done;
   logic [31:0] blk_bytes, blk_bits;

   logic        f1_s_valid, f1_s_ready, f1_s_y, f1_s_last;
   logic [31:0] f1_s_p;
   logic        f1_enc_rst, f1_enc_start, f1_enc_y, f1_enc_in_valid, f1_enc_in_ready;
   logic [31:0] f1_enc_p, f1_enc_low;
   logic [7:0]  f1_enc_out;
   logic        f1_enc_out_valid, f1_enc_out_ready;
   logic [7:0]  f1_m_data;
   logic        f1_m_valid, f1_m_ready, f1_m_last, f1_busy, f1_blk_done;
   logic [31:0] f1_blk_bytes, f1_blk_bits;

   arith_enc_sched #(.Prob_DW(32), .FLUSH_BYTES(4), .Cnt_DW(32)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_y(s_y), .s_p(s_p),
      .s_last(s_last), .enc_rst(enc_rst), .enc_start(enc_start), .enc_y(enc_y), .enc_p(enc_p),
      .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready), .enc_out(enc_out),
      .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready), .enc_low(enc_low),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
      .blk_done(blk_done), .blk_bytes(blk_bytes), .blk_bits(blk_bits));

   arith_enc_sched #(.Prob_DW(32), .FLUSH_BYTES(1), .Cnt_DW(32)) dut_f1 (
      .clk(clk), .rst(rst), .s_valid(f1_s_valid), .s_ready(f1_s_ready), .s_y(f1_s_y),
      .s_p(f1_s_p), .s_last(f1_s_last), .enc_rst(f1_enc_rst), .enc_start(f1_enc_start),
      .enc_y(f1_enc_y), .enc_p(f1_enc_p), .enc_in_valid(f1_enc_in_valid),
      .enc_in_ready(f1_enc_in_ready), .enc_out(f1_enc_out), .enc_out_valid(f1_enc_out_valid),
      .enc_out_ready(f1_enc_out_ready), .enc_low(f1_enc_low), .m_data(f1_m_data),
      .m_valid(f1_m_valid), .m_ready(f1_m_ready), .m_last(f1_m_last), .busy(f1_busy),
      .blk_done(f1_blk_done), .blk_bytes(f1_blk_bytes), .blk_bits(f1_blk_bits));

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One coding step of a carry-less binary arithmetic coder; returns up to 4 settled bytes.
   function automatic void code_pair(inout logic [31:0] hi, inout logic [31:0] lo,
                                     input logic y, input logic [15:0] p,
                                     output int nb, output logic [31:0] ob);
      logic [31:0] r, mid;
      r   = hi - lo;
      mid = lo + (r >> 16) * {16'h0, p} + (((r & 32'hffff) * {16'h0, p}) >> 16);
      if (y) hi = mid;
      else   lo = mid + 32'd1;
      nb = 0;
      ob = '0;
      while (((hi ^ lo) & 32'hff00_0000) == 0 && nb < 4) begin
         ob = {ob[23:0], hi[31:24]};
         nb++;
         hi = {hi[23:0], 8'hff};
         lo = {lo[23:0], 8'h00};
      end
   endfunction

   logic        src_y[$];
   logic [15:0] src_p[$];
   logic        src_l[$];
   logic [8:0]  exp_q[$];
   int          exp_cnt[$], exp_bits[$];
   logic [8:0]  got_q[$], ref_b[$];
   logic [7:0]  outq[$];
   logic [31:0] hi, lo;
   int          done_cnt = 0, n_rst = 0, n_start = 0, blk_got = 0, last_enc_nb = 0, cyc = 0;
   int          first_valid = -1, first_fire = -1;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   logic        rand_mr = 1'b0, rand_ir = 1'b0;

   // Reference: a fresh encoder per block, then FLUSH_BYTES=4 bytes of final Low, MSB first.
   task automatic add_block(input int n, input bit fixed, input logic fy, input logic [15:0] fp);
      logic [31:0] h, l, ob;
      logic        y;
      logic [15:0] p;
      int          nb, total;
      h = 32'hffff_ffff;
      l = 32'd1;
      total = 0;
      for (int i = 0; i < n; i++) begin
         y = fixed ? fy : 1'($urandom % 2);
         p = fixed ? fp : 16'($urandom_range(1, 65535));
         src_y.push_back(y);
         src_p.push_back(p);
         src_l.push_back(i == n - 1);
         code_pair(h, l, y, p, nb, ob);
         for (int k = nb - 1; k >= 0; k--) exp_q.push_back({1'b0, ob[8*k +: 8]});
         total += nb;
      end
      for (int f = 0; f < 4; f++) exp_q.push_back({f == 3, l[31 - 8*f -: 8]});
      last_enc_nb = total;
      exp_cnt.push_back(total + 4);
      exp_bits.push_back(n);
   endtask

   task automatic drive();
      s_valid = (src_y.size() > 0);
      s_y     = s_valid ? src_y[0] : 1'($urandom % 2);
      s_p     = s_valid ? {16'h0, src_p[0]} : 32'($urandom);
      s_last  = s_valid ? src_l[0] : 1'($urandom % 2);
      m_ready = rand_mr ? 1'($urandom % 2) : 1'b1;
      enc_out_valid = (outq.size() > 0);
      enc_out       = enc_out_valid ? outq[0] : 8'h00;
      enc_in_ready  = (outq.size() == 0) && (!rand_ir || ($urandom % 2) == 1);
      enc_low       = lo;
   endtask

   // Sample at negedge, update encoder stub and source just after the posedge.
   task automatic tick();
      logic rs, er, sf, inf, of, mf, iy;
      logic [31:0] ip, ob;
      int nb;
      @(negedge clk);
      cyc++;
      rs  = rst;
      er  = enc_rst;
      sf  = s_valid & s_ready;
      inf = enc_in_valid & enc_in_ready;
      of  = enc_out_valid & enc_out_ready;
      mf  = m_valid & m_ready;
      iy  = enc_y;
      ip  = enc_p;
      if (!rs) begin
         if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
         end
         if (inf) chk("enc_pair", {enc_y, enc_p}, {s_y, s_p});
         if (mf) begin
            got_q.push_back({m_last, m_data});
            if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
            else                   chk("byte", {m_last, m_data}, exp_q.pop_front());
            blk_got++;
         end
         if (blk_done) begin
            done_cnt++;
            blk_got = 0;
            if (exp_cnt.size() == 0) chk("extra_done", exp_cnt.size(), 1);
            else begin
               chk("blk_bytes", blk_bytes, exp_cnt.pop_front());
               chk("blk_bits", blk_bits, exp_bits.pop_front());
            end
         end
         if (enc_rst)   n_rst++;
         if (enc_start) n_start++;
         if (s_valid && !busy && first_valid < 0) first_valid = cyc;
         if (sf && first_fire < 0) first_fire = cyc;
      end
      prev_stall = !rs && m_valid && !m_ready;
      prev_data  = m_data;
      @(posedge clk);
      #1;
      if (rs || er) begin
         hi = 32'hffff_ffff;
         lo = 32'd1;
         outq.delete();
      end else begin
         if (of) void'(outq.pop_front());
         if (inf) begin
            code_pair(hi, lo, iy, ip[15:0], nb, ob);
            for (int k = nb - 1; k >= 0; k--) outq.push_back(ob[8*k +: 8]);
         end
      end
      if (sf && !rs) begin
         void'(src_y.pop_front());
         void'(src_p.pop_front());
         void'(src_l.pop_front());
      end
      drive();
   endtask

   task automatic wait_done(input int target);
      int t = 0;
      while (done_cnt < target && t < 20000) begin
         tick();
         t++;
      end
      if (done_cnt < target) chk("timeout", done_cnt, target);
      repeat (4) tick();
      chk("done_pulses", done_cnt, target);
      chk("exp_drained", exp_q.size(), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int mism, t, d1;
      logic [8:0]  g1[$];
      logic [31:0] bb1, bits1;
      logic        fire1;

      rst = 1'b1;
      hi = 32'hffff_ffff;
      lo = 32'd1;
      f1_s_valid = 1'b0; f1_s_y = 1'b1; f1_s_p = 32'h8000; f1_s_last = 1'b1;
      f1_enc_in_ready = 1'b1; f1_enc_out = 8'h00; f1_enc_out_valid = 1'b0;
      f1_enc_low = 32'd1; f1_m_ready = 1'b1;
      drive();
      tick();
      tick();
      // Reset state with active-looking inputs presented.
      s_valid = 1'b1; m_ready = 1'b1; enc_in_ready = 1'b1; enc_out_valid = 1'b1;
      #1;
      chk("rst_handshake", {s_ready, m_valid, m_last, enc_in_valid, enc_out_ready}, 5'b0);
      chk("rst_ctrl", {busy, blk_done, enc_rst, enc_start}, 4'b0);
      chk("rst_blk_bytes", blk_bytes, 0);
      chk("rst_blk_bits", blk_bits, 0);
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single pair y=1 p=0x8000
      got_q.delete();
      n_rst = 0; n_start = 0;
      add_block(1, 1'b1, 1'b1, 16'h8000);
      drive();
      wait_done(done_cnt + 1);
      chk("a_len", got_q.size(), 4);
      if (got_q.size() == 4)
         chk("a_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, {9'h000, 9'h000, 9'h000, 9'h101});
      chk("a_enc_rst", n_rst, 1);
      chk("a_enc_start", n_start, 1);
      chk("a_latency_ge2", (first_fire - first_valid) >= 2, 1);

      // 64 pairs y=0 p=0xFFFF with full-rate sinks
      got_q.delete();
      add_block(64, 1'b1, 1'b0, 16'hffff);
      wait_done(done_cnt + 1);
      ref_b = got_q;

      // Same block with 50% m_ready and a stalling encoder
      got_q.delete();
      rand_mr = 1'b1; rand_ir = 1'b1;
      add_block(64, 1'b1, 1'b0, 16'hffff);
      wait_done(done_cnt + 1);
      chk("c_len", got_q.size(), ref_b.size());
      mism = 0;
      for (int i = 0; i < got_q.size() && i < ref_b.size(); i++)
         if (got_q[i] !== ref_b[i]) mism++;
      chk("c_stream_mism", mism, 0);

      // Four random back-to-back blocks
      n_rst = 0; n_start = 0;
      for (int b = 0; b < 4; b++) add_block($urandom_range(1, 24), 1'b0, 1'b0, 16'h0);
      wait_done(done_cnt + 4);
      chk("d_enc_rst", n_rst, 4);
      chk("d_enc_start", n_start, 4);

      // Reset while the second flush byte is presented
      rand_mr = 1'b0; rand_ir = 1'b0;
      add_block(10, 1'b0, 1'b0, 16'h0);
      t = 0;
      while (blk_got != last_enc_nb + 1 && t < 5000) begin
         tick();
         t++;
      end
      chk("e_reach_flush", blk_got, last_enc_nb + 1);
      rst = 1'b1;
      m_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk("e_m_valid", m_valid, 0);
      chk("e_busy", busy, 0);
      chk("e_blk_cleared", {blk_bytes, blk_bits}, 64'h0);
      exp_q.delete(); exp_cnt.delete(); exp_bits.delete();
      src_y.delete(); src_p.delete(); src_l.delete();
      blk_got = 0; prev_stall = 1'b0;
      n_rst = 0;
      add_block(12, 1'b0, 1'b0, 16'h0);
      drive();
      wait_done(done_cnt + 1);
      chk("e_enc_rst", n_rst, 1);

      // FLUSH_BYTES=1 instance, single pair y=1 p=0x8000
      d1 = 0; bb1 = '0; bits1 = '0; fire1 = 1'b0;
      f1_s_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         fire1 = f1_s_valid && f1_s_ready;
         if (f1_m_valid && f1_m_ready) g1.push_back({f1_m_last, f1_m_data});
         if (f1_blk_done) begin
            d1++;
            bb1   = f1_blk_bytes;
            bits1 = f1_blk_bits;
         end
         @(posedge clk);
         #1;
         if (fire1) f1_s_valid = 1'b0;
      end
      chk("f1_len", g1.size(), 1);
      if (g1.size() > 0) chk("f1_byte", g1[0], 9'h100);
      chk("f1_blk_bytes", bb1, 1);
      chk("f1_blk_bits", bits1, 1);
      chk("f1_done", d1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arith_enc_sched.md
# arith_enc_sched

Block-level sequencer for the binary arithmetic encoder in the compression pipeline. It takes a per-block stream of (bit, probability) pairs from the context model and reinitialises and starts the encoder for each block. It forwards pairs one at a time and merges the encoder's byte output with a trailing flush of the final `Low` register into one byte stream. It also reports the per-block compressed byte count to the block-framing logic.

## Interface
Parameters:
- `Prob_DW`, 32: probability width; also the width of encoder `Low`.
- `FLUSH_BYTES`, 4: number of `Low` bytes emitted at block end, MSB first; legal range 1..4.
- `Cnt_DW`, 32: width of the byte and bit counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid` / `s_ready`  in / out  1  upstream pair handshake.
- `s_y`  in  1  bit to code.
- `s_p`  in  `Prob_DW`  probability of a 1, 16-bit fraction.
- `s_last`  in  1  marks the last pair of the block.
- `enc_rst`  out  1  encoder reinitialise, High=FFFFFFFF, Low=1.
- `enc_start`  out  1  encoder start pulse.
- `enc_y`, `enc_p`, `enc_in_valid`  out  1 / `Prob_DW` / 1  pair to encoder.
- `enc_in_ready`  in  1  encoder accepting a pair.
- `enc_out`  in  8  encoder byte.
- `enc_out_valid`  in  1  encoder byte valid.
- `enc_out_ready`  out  1  encoder byte accepted.
- `enc_low`  in  `Prob_DW`  encoder `Low` register.
- `m_data`  out  8  output byte.
- `m_valid`  out  1  output byte valid.
- `m_ready`  in  1  downstream ready.
- `m_last`  out  1  marks the last byte of the block.
- `busy`  out  1  high in any state except IDLE.
- `blk_done`  out  1  one-cycle pulse at block end.
- `blk_bytes`  out  `Cnt_DW`  bytes emitted for the last completed block, including flush bytes.
- `blk_bits`  out  `Cnt_DW`  pairs coded for the last completed block.

## Operation
- State machine:
  - IDLE → RST when `s_valid`=1.
  - RST → START after one cycle.
  - START → FEED after one cycle.
  - FEED → DRAIN on a handshake with `s_last`=1.
  - DRAIN → FLUSH when quiescent.
  - FLUSH → DONE after the final flush byte handshake.
  - DONE → IDLE after one cycle.
- RST: `enc_rst`=1 for exactly one cycle.
- START: `enc_start`=1 for exactly one cycle.
- FEED: pass-through, combinational.
  - `enc_in_valid`=`s_valid`, `s_ready`=`enc_in_ready`.
  - `enc_y`=`s_y`, `enc_p`=`s_p`.
  - `s_ready`=0 in all other states. `enc_in_valid`=0 outside FEED.
- Byte path in FEED and DRAIN:
  - `m_data`=`enc_out`, `m_valid`=`enc_out_valid`, `enc_out_ready`=`m_ready`.
  - A single pair can produce 0..4 bytes; all of them are forwarded.
- DRAIN quiescence requires both conditions:
  - at least one cycle has passed since the last input handshake;
  - `enc_in_ready`=1 and `enc_out_valid`=0 in the same cycle.
- FLUSH: `enc_low` is latched on entry.
  - Latched bytes `[31:24]`, `[23:16]`, … are emitted, `FLUSH_BYTES` of them.
  - `m_last`=1 only with the final flush byte.
  - `enc_out_ready`=0.
- Counters:
  - The byte counter increments on every `m_valid & m_ready`.
  - The bit counter increments on every FEED handshake.
  - Both clear in RST.
  - Both are copied to `blk_bytes` / `blk_bits` in DONE. `blk_done`=1 in DONE.
- Width rule: counters saturate at all-ones; they do not wrap.
- Every block holds at least one pair. A block whose first pair has `s_last`=1 is legal and codes 1 bit.

## Timing
- Reset values:
  - state IDLE;
  - `enc_rst`=0, `enc_start`=0, `enc_in_valid`=0, `enc_out_ready`=0;
  - `s_ready`=0, `m_valid`=0, `m_last`=0, `busy`=0, `blk_done`=0;
  - `blk_bytes`=0, `blk_bits`=0.
- Reset mid-block:
  - next state IDLE; the in-flight pair and any flush bytes are dropped;
  - `blk_bytes` and `blk_bits` are cleared;
  - the encoder is reinitialised on the next block via RST.
- Startup latency: first `s_ready` no earlier than 2 cycles after IDLE sees `s_valid`. The first pair is not consumed in IDLE.
- Throughput: one pair per encoder SetIn window. The scheduler adds zero cycles in FEED.
- Flush byte i is presented the cycle after byte i-1 handshakes. `m_data` is held stable while `m_valid & ~m_ready`.
- `s_last`: only its value at handshake matters.
- The next block's IDLE→RST transition may begin the cycle after DONE.

## Test plan
- Single pair y=1, p=0x8000 → `m_data` 00,00,00,01 with `m_last` on the 4th byte; `blk_bytes`=4, `blk_bits`=1, `blk_done` pulses once.
- 64 pairs y=0, p=0xFFFF → encoder bytes forwarded in order, then 4 flush bytes; `blk_bytes` equals the byte count from a C++ model; `blk_bits`=64.
- Random `m_ready` (50% duty) during FEED and FLUSH → byte stream identical to the `m_ready`=1 run; no byte lost or duplicated; `m_data` stable while stalled.
- `FLUSH_BYTES`=1, single pair y=1, p=0x8000 → one flush byte 00 with `m_last`; `blk_bytes`=1.
- `rst` asserted during the 2nd flush byte → `m_valid`=0 next cycle and `busy`=0; the following block restarts with `enc_rst` and its output matches a fresh-block run.
- Two back-to-back blocks → `enc_rst`/`enc_start` pulse once per block; the second block's bytes match an isolated run.
